rtc_escritura: RTL and testbench

Write-cycle generator for the RTC's multiplexed address/data bus. It is the counterpart of the existing read sequencer.
- On `inicio` it performs an address phase, writing the register address with AD low.
- It then performs a data phase, writing the data byte with AD high.
- All timing comes from an internal per-state cycle counter.
- It sits between the top-level control FSM and the RTC pins, sharing the AD/CS/WR/RD lines with the reader through the top-level mux.

---
 rtl/rtc_escritura.sv | 188 ++++++++++++++++++
 tb/tb_rtc_escritura.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_escritura.sv
// rtc_escritura: write-cycle generator for the RTC multiplexed address/data bus (address phase, then data phase).
// Define RTC_ABORT_EN to add the abortar input and error_flag output (abort with recovery).
module rtc_escritura #(
    parameter int CNT_W = 9,
    parameter int T_SU  = 10,
    parameter int T_PW  = 40,
    parameter int T_HD  = 10,
    parameter int T_REC = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic [7:0] dir,
    input  logic [7:0] dato,
`ifdef RTC_ABORT_EN
    input  logic       abortar,
    output logic       error_flag,
`endif
    output logic       AD_reg,
    output logic       CS_reg,
    output logic       WR_reg,
    output logic       RD_reg,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       ocupado,
    output logic       end_flag
);

    typedef enum logic [3:0] {
        IDLE, A_AD, A_CS, A_WR, A_HD, A_REC, D_CS, D_WR, D_HD, D_REC, DONE, ABORT_REC
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lastCnt;
    logic             lastCycle;
    logic [7:0]       dirLatch_q, dirLatch_d, datoLatch_q, datoLatch_d;
    logic             ad_q, ad_d, cs_q, cs_d, wr_q, wr_d, oe_q, oe_d;
    logic             ocupado_q, ocupado_d, end_q, end_d;
    logic [7:0]       bus_q, bus_d;
    logic             abortReq;

`ifdef RTC_ABORT_EN
    logic err_q, err_d;
    assign abortReq = abortar;
`else
    assign abortReq = 1'b0;
`endif

    always_comb begin
        lastCnt = '0;
        case (state_q)
            A_AD, A_CS, D_CS:       lastCnt = CNT_W'(T_SU - 1);
            A_WR, D_WR:             lastCnt = CNT_W'(T_PW - 1);
            A_HD, D_HD:             lastCnt = CNT_W'(T_HD - 1);
            A_REC, D_REC, ABORT_REC: lastCnt = CNT_W'(T_REC - 1);
            default:                lastCnt = '0;
        endcase
    end

    assign lastCycle = (cnt_q == lastCnt);

    always_comb begin
        state_d     = state_q;
        dirLatch_d  = dirLatch_q;
        datoLatch_d = datoLatch_q;
        case (state_q)
            IDLE: begin
                if (inicio) begin
                    state_d     = A_AD;
                    dirLatch_d  = dir;
                    datoLatch_d = dato;
                end
            end
            A_AD:      if (lastCycle) state_d = A_CS;
            A_CS:      if (lastCycle) state_d = A_WR;
            A_WR:      if (lastCycle) state_d = A_HD;
            A_HD:      if (lastCycle) state_d = A_REC;
            A_REC:     if (lastCycle) state_d = D_CS;
            D_CS:      if (lastCycle) state_d = D_WR;
            D_WR:      if (lastCycle) state_d = D_HD;
            D_HD:      if (lastCycle) state_d = D_REC;
            D_REC:     if (lastCycle) state_d = DONE;
            DONE:      state_d = IDLE;
            ABORT_REC: if (lastCycle) state_d = DONE;
            default:   state_d = IDLE;
        endcase
        // An abort overrides any in-flight phase but never the wind-down states.
        if (abortReq && state_q != IDLE && state_q != DONE && state_q != ABORT_REC) begin
            state_d = ABORT_REC;
        end
        cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
    end

    // Pin values are decoded from the next state so they register together with it.
    always_comb begin
        ad_d      = 1'b1;
        cs_d      = 1'b1;
        wr_d      = 1'b1;
        oe_d      = 1'b0;
        bus_d     = 8'h00;
        end_d     = 1'b0;
        ocupado_d = (state_d != IDLE);
        case (state_d)
            A_AD: ad_d = 1'b0;
            A_CS: begin
                ad_d = 1'b0;
                cs_d = 1'b0;
            end
            A_WR: begin
                ad_d  = 1'b0;
                cs_d  = 1'b0;
                wr_d  = 1'b0;
                oe_d  = 1'b1;
                bus_d = dirLatch_q;
            end
            A_HD: begin
                ad_d  = 1'b0;
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                bus_d = dirLatch_q;
            end
            D_CS: cs_d = 1'b0;
            D_WR: begin
                cs_d  = 1'b0;
                wr_d  = 1'b0;
                oe_d  = 1'b1;
                bus_d = datoLatch_q;
            end
            D_HD: begin
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                bus_d = datoLatch_q;
            end
            DONE:    end_d = 1'b1;
            default: ;
        endcase
`ifdef RTC_ABORT_EN
        err_d = (state_d == DONE) && (state_q == ABORT_REC);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dirLatch_q  <= 8'h00;
            datoLatch_q <= 8'h00;
            ad_q        <= 1'b1;
            cs_q        <= 1'b1;
            wr_q        <= 1'b1;
            oe_q        <= 1'b0;
            bus_q       <= 8'h00;
            ocupado_q   <= 1'b0;
            end_q       <= 1'b0;
`ifdef RTC_ABORT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dirLatch_q  <= dirLatch_d;
            datoLatch_q <= datoLatch_d;
            ad_q        <= ad_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            oe_q        <= oe_d;
            bus_q       <= bus_d;
            ocupado_q   <= ocupado_d;
            end_q       <= end_d;
`ifdef RTC_ABORT_EN
            err_q       <= err_d;
`endif
        end
    end

    assign AD_reg   = ad_q;
    assign CS_reg   = cs_q;
    assign WR_reg   = wr_q;
    assign RD_reg   = 1'b1;
    assign bus_out  = bus_q;
    assign bus_oe   = oe_q;
    assign ocupado  = ocupado_q;
    assign end_flag = end_q;
`ifdef RTC_ABORT_EN
    assign error_flag = err_q;
`endif

endmodule

// File: tb/tb_rtc_escritura.sv
// tb_rtc_escritura: drives a default-timing and a minimum-timing rtc_escritura from shared inputs
// and checks both every cycle against a phase-table model of the write sequence.
module tb_rtc_escritura;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic       abortar = 1'b0;
    logic [7:0] dir = 8'h00;
    logic [7:0] dato = 8'h00;
    logic [1:0] ad, cs, wr, rd, oe, ocu, endf, errf;
    logic [7:0] bus [2];

    int  nTotal = 0;
    int  nBad = 0;
    bit  cmpEn = 1'b0;

    int pSu[2]  = '{10, 1};
    int pPw[2]  = '{40, 1};
    int pHd[2]  = '{10, 1};
    int pRec[2] = '{20, 1};

`ifdef RTC_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
    assign errf = 2'b00;
`endif

    always #5 clk = ~clk;

    rtc_escritura dutA (
        .clk(clk), .reset(reset), .inicio(inicio), .dir(dir), .dato(dato),
`ifdef RTC_ABORT_EN
        .abortar(abortar), .error_flag(errf[0]),
`endif
        .AD_reg(ad[0]), .CS_reg(cs[0]), .WR_reg(wr[0]), .RD_reg(rd[0]),
        .bus_out(bus[0]), .bus_oe(oe[0]), .ocupado(ocu[0]), .end_flag(endf[0])
    );

    rtc_escritura #(.CNT_W(9), .T_SU(1), .T_PW(1), .T_HD(1), .T_REC(1)) dutB (
        .clk(clk), .reset(reset), .inicio(inicio), .dir(dir), .dato(dato),
`ifdef RTC_ABORT_EN
        .abortar(abortar), .error_flag(errf[1]),
`endif
        .AD_reg(ad[1]), .CS_reg(cs[1]), .WR_reg(wr[1]), .RD_reg(rd[1]),
        .bus_out(bus[1]), .bus_oe(oe[1]), .ocupado(ocu[1]), .end_flag(endf[1])
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        nTotal++;
        if (actual !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a write is just an offset into the phase table, or an offset into the abort recovery.
    bit         mBusy[2], mAbort[2];
    int         mOff[2], mAbOff[2];
    logic [7:0] mDir[2], mDato[2];

    function automatic int totalCycles(int k);
        return 3 * pSu[k] + 2 * pPw[k] + 2 * pHd[k] + 2 * pRec[k];
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                mBusy[k]  = 1'b0;
                mAbort[k] = 1'b0;
            end else if (!mBusy[k]) begin
                if (inicio) begin
                    mBusy[k]  = 1'b1;
                    mAbort[k] = 1'b0;
                    mOff[k]   = 0;
                    mDir[k]   = dir;
                    mDato[k]  = dato;
                end
            end else if (mAbort[k]) begin
                mAbOff[k]++;
                if (mAbOff[k] > pRec[k]) mBusy[k] = 1'b0;
            end else if (ABORT_ON && abortar && mOff[k] < totalCycles(k)) begin
                mAbort[k] = 1'b1;
                mAbOff[k] = 0;
            end else begin
                mOff[k]++;
                if (mOff[k] > totalCycles(k)) mBusy[k] = 1'b0;
            end
        end
    end

    typedef struct packed {
        logic       ad, cs, wr, oe;
        logic [7:0] bus;
        logic       ocu, endf, errf;
    } exp_t;

    function automatic exp_t expectOut(int k);
        exp_t e;
        int   d[9];
        int   t;
        int   ph;
        bit   found;
        e = '0;
        e.ad = 1'b1; e.cs = 1'b1; e.wr = 1'b1;
        if (!mBusy[k]) return e;
        e.ocu = 1'b1;
        if (mAbort[k]) begin
            if (mAbOff[k] == pRec[k]) begin
                e.endf = 1'b1;
                e.errf = 1'b1;
            end
            return e;
        end
        d = '{pSu[k], pSu[k], pPw[k], pHd[k], pRec[k], pSu[k], pPw[k], pHd[k], pRec[k]};
        t = mOff[k];
        ph = 9;
        found = 1'b0;
        for (int p = 0; p < 9; p++) begin
            if (!found) begin
                if (t < d[p]) begin
                    ph = p;
                    found = 1'b1;
                end else begin
                    t -= d[p];
                end
            end
        end
        case (ph)
            0: e.ad = 1'b0;
            1: begin e.ad = 1'b0; e.cs = 1'b0; end
            2: begin e.ad = 1'b0; e.cs = 1'b0; e.wr = 1'b0; e.oe = 1'b1; e.bus = mDir[k]; end
            3: begin e.ad = 1'b0; e.cs = 1'b0; e.oe = 1'b1; e.bus = mDir[k]; end
            5: e.cs = 1'b0;
            6: begin e.cs = 1'b0; e.wr = 1'b0; e.oe = 1'b1; e.bus = mDato[k]; end
            7: begin e.cs = 1'b0; e.oe = 1'b1; e.bus = mDato[k]; end
            9: e.endf = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    logic [1:0] prevWr = 2'b11;
    logic [1:0] prevCs = 2'b11;

    always @(negedge clk) begin
        if (cmpEn) begin
            for (int k = 0; k < 2; k++) begin
                exp_t e;
                e = expectOut(k);
                checkOutput($sformatf("dut%0d.AD", k), 8'(ad[k]), 8'(e.ad));
                checkOutput($sformatf("dut%0d.CS", k), 8'(cs[k]), 8'(e.cs));
                checkOutput($sformatf("dut%0d.WR", k), 8'(wr[k]), 8'(e.wr));
                checkOutput($sformatf("dut%0d.RD", k), 8'(rd[k]), 8'h01);
                checkOutput($sformatf("dut%0d.oe", k), 8'(oe[k]), 8'(e.oe));
                checkOutput($sformatf("dut%0d.bus", k), bus[k], e.bus);
                checkOutput($sformatf("dut%0d.ocupado", k), 8'(ocu[k]), 8'(e.ocu));
                checkOutput($sformatf("dut%0d.end", k), 8'(endf[k]), 8'(e.endf));
`ifdef RTC_ABORT_EN
                checkOutput($sformatf("dut%0d.error", k), 8'(errf[k]), 8'(e.errf));
`endif
                checkOutput($sformatf("dut%0d.invOeNoCs", k), 8'(oe[k] & cs[k]), 8'h00);
                checkOutput($sformatf("dut%0d.invWrCsFall", k),
                            8'(prevWr[k] & ~wr[k] & prevCs[k] & ~cs[k]), 8'h00);
                prevWr[k] = wr[k];
                prevCs[k] = cs[k];
            end
        end
    end

    // Cycle-level observations used by the hand-computed checks.
    int         cyc = 0;
    int         startCyc[2], rises[2], lastGap[2], idleRun[2], ocuCnt[2];
    int         endCnt[2], endOff[2], addrCnt[2], dataCnt[2];
    logic [7:0] addrBus[2], dataBus[2];
    logic [1:0] monPrevOcu = 2'b00;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (ocu[k] && !monPrevOcu[k]) begin
                startCyc[k] = cyc;
                rises[k]++;
                lastGap[k] = idleRun[k];
            end
            if (!ocu[k]) idleRun[k]++;
            else idleRun[k] = 0;
            if (ocu[k]) ocuCnt[k]++;
            if (endf[k]) begin
                endCnt[k]++;
                endOff[k] = cyc - startCyc[k];
            end
            if (!wr[k] && !ad[k]) begin
                addrCnt[k]++;
                addrBus[k] = bus[k];
            end
            if (!wr[k] && ad[k]) begin
                dataCnt[k]++;
                dataBus[k] = bus[k];
            end
            monPrevOcu[k] = ocu[k];
        end
    end

    task automatic clearMon();
        for (int k = 0; k < 2; k++) begin
            rises[k] = 0; lastGap[k] = 0; idleRun[k] = 0; ocuCnt[k] = 0;
            endCnt[k] = 0; endOff[k] = 0; addrCnt[k] = 0; dataCnt[k] = 0;
            addrBus[k] = 8'h00; dataBus[k] = 8'h00;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] dirV, input logic [7:0] datoV);
        @(posedge clk);
        clearMon();
        @(negedge clk);
        dir = dirV;
        dato = datoV;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        cmpEn = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst.AD", 8'(ad[0]), 8'h01);
        checkOutput("rst.CS", 8'(cs[0]), 8'h01);
        checkOutput("rst.WR", 8'(wr[0]), 8'h01);
        checkOutput("rst.oe", 8'(oe[0]), 8'h00);
        checkOutput("rst.ocupado", 8'(ocu[0]), 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic write 21/45");
        applyStimulus(8'h21, 8'h45);
        repeat (180) @(negedge clk);
        @(posedge clk);
        checkOutput("w1.addrCycles", 8'(addrCnt[0]), 8'd40);
        checkOutput("w1.addrBus", addrBus[0], 8'h21);
        checkOutput("w1.dataCycles", 8'(dataCnt[0]), 8'd40);
        checkOutput("w1.dataBus", dataBus[0], 8'h45);
        checkOutput("w1.endCount", 8'(endCnt[0]), 8'd1);
        checkOutput("w1.endOffset", 8'(endOff[0]), 8'd170);
        checkOutput("min.endCount", 8'(endCnt[1]), 8'd1);
        checkOutput("min.endOffset", 8'(endOff[1]), 8'd9);
        checkOutput("min.busyCycles", 8'(ocuCnt[1]), 8'd10);
        checkOutput("min.addrBus", addrBus[1], 8'h21);

        $display("[TB] held start with late input changes");
        @(posedge clk);
        clearMon();
        @(negedge clk);
        dir = 8'h21;
        dato = 8'h45;
        inicio = 1'b1;
        @(negedge clk);
        dir = 8'h9C;
        dato = 8'h3E;
        repeat (173) @(negedge clk);
        inicio = 1'b0;
        @(posedge clk);
        checkOutput("hold.addrBus", addrBus[0], 8'h21);
        checkOutput("hold.dataBus", dataBus[0], 8'h45);
        checkOutput("hold.addrCycles", 8'(addrCnt[0]), 8'd40);
        checkOutput("hold.rises", 8'(rises[0]), 8'd2);
        checkOutput("hold.idleGap", 8'(lastGap[0]), 8'd1);
        repeat (200) @(negedge clk);
        @(posedge clk);
        checkOutput("hold.addrBus2", addrBus[0], 8'h9C);
        checkOutput("hold.dataBus2", dataBus[0], 8'h3E);
        checkOutput("hold.endCount", 8'(endCnt[0]), 8'd2);

        $display("[TB] reset during data strobe");
        applyStimulus(8'h5A, 8'hC3);
        repeat (115) @(negedge clk);
        checkOutput("rstMid.dataStrobe", {6'd0, ad[0], wr[0]}, 8'h02);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstMid.AD", 8'(ad[0]), 8'h01);
        checkOutput("rstMid.CS", 8'(cs[0]), 8'h01);
        checkOutput("rstMid.WR", 8'(wr[0]), 8'h01);
        checkOutput("rstMid.oe", 8'(oe[0]), 8'h00);
        checkOutput("rstMid.ocupado", 8'(ocu[0]), 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        @(posedge clk);
        checkOutput("rstMid.noEnd", 8'(endCnt[0]), 8'd0);

`ifdef RTC_ABORT_EN
        $display("[TB] abort during address strobe");
        applyStimulus(8'h77, 8'h88);
        repeat (30) @(negedge clk);
        checkOutput("abort.inAddrStrobe", 8'(wr[0]), 8'h00);
        abortar = 1'b1;
        @(negedge clk);
        abortar = 1'b0;
        checkOutput("abort.wrReleased", 8'(wr[0]), 8'h01);
        checkOutput("abort.oeReleased", 8'(oe[0]), 8'h00);
        checkOutput("abort.stillBusy", 8'(ocu[0]), 8'h01);
        repeat (19) @(negedge clk);
        checkOutput("abort.noEarlyEnd", 8'(endf[0]), 8'h00);
        @(negedge clk);
        checkOutput("abort.end", 8'(endf[0]), 8'h01);
        checkOutput("abort.error", 8'(errf[0]), 8'h01);
        @(negedge clk);
        checkOutput("abort.idle", 8'(ocu[0]), 8'h00);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
